// File: rtl/mux_arbiter_2x1.sv
// mux_arbiter_2x1: two requesters share one 4-bit datapath through a
// round-robin arbiter. OUT, SEL, grants and VALID are all registered.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces a hand-over
// after MAX_HOLD consecutive grant cycles when the other side is waiting.
//
// state  | meaning
// IDLE   | nobody owns the datapath, OUT forced to zero
// GRANT0 | requester 0 owns the datapath, SEL=0
// GRANT1 | requester 1 owns the datapath, SEL=1
module mux_arbiter_2x1 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       SEL,
  output logic [3:0] OUT,
  output logic       VALID
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // The hold limit only matters with the timeout build, but an out-of-range
  // value is a configuration mistake in either build.
  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("mux_arbiter_2x1: MAX_HOLD must be within 2..15");
  end

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic [3:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

  logic [3:0] hold_q, hold_d;

  // Forced hand-over only when the owner has used up its slot and the other side waits.
  always_comb begin
    timeout = (hold_q == HOLD_LIMIT) &&
              (((state_q == GRANT0) && REQ1) || ((state_q == GRANT1) && REQ0));
  end

  // Hold counter: clears on any grant entry, counts grant cycles, saturates at the limit.
  always_comb begin
    hold_d = 4'd0;
    if ((state_d != IDLE) && (state_d == state_q)) begin
      hold_d = (hold_q == HOLD_LIMIT) ? hold_q : hold_q + 4'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output decode for the arbiter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (REQ0 && REQ1)  state_d = last_q ? GRANT0 : GRANT1;
        else if (REQ0)     state_d = GRANT0;
        else if (REQ1)     state_d = GRANT1;
        else               state_d = IDLE;
      end
      GRANT0: begin
        if (timeout)       state_d = GRANT1;
        else if (REQ0)     state_d = GRANT0;
        else if (REQ1)     state_d = GRANT1;
        else               state_d = IDLE;
      end
      GRANT1: begin
        if (timeout)       state_d = GRANT0;
        else if (REQ1)     state_d = GRANT1;
        else if (REQ0)     state_d = GRANT0;
        else               state_d = IDLE;
      end
      default:             state_d = IDLE;
    endcase

    last_d = last_q;
    sel_d  = sel_q;
    if (state_d == GRANT0) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (state_d == GRANT1) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end

    // Data path follows the current owner, so OUT lags the grant by one cycle.
    case (state_q)
      GRANT0:  out_d = D0;
      GRANT1:  out_d = D1;
      default: out_d = 4'b0000;
    endcase
    valid_d = (state_q != IDLE);
  end

  // State, pointer and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      out_q   <= 4'b0000;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign GNT0  = (state_q == GRANT0);
  assign GNT1  = (state_q == GRANT1);
  assign SEL   = sel_q;
  assign OUT   = out_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// Testbench for mux_arbiter_2x1: directed scenarios followed by random
// request traffic, every cycle compared against a behavioural owner model.
module tb_mux_arbiter_2x1;

  localparam int MAX_HOLD = 8;

  logic       clock;
  logic       reset;
  logic       REQ0, REQ1;
  logic [3:0] D0, D1;
  logic       GNT0, GNT1, SEL, VALID;
  logic [3:0] OUT;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who owns the datapath (-1 = nobody) and for how long.
  int         m_owner;
  int         m_last;
  int         m_held;
  logic       m_sel;
  logic [3:0] m_out;
  logic       m_valid;

  mux_arbiter_2x1 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .REQ0  (REQ0),
    .REQ1  (REQ1),
    .D0    (D0),
    .D1    (D1),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .SEL   (SEL),
    .OUT   (OUT),
    .VALID (VALID)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs presented to the DUT.
  task automatic model_edge();
    int         nxt;
    int         other;
    bit         forced;
    logic [3:0] n_out;
    logic       req [2];
    if (!reset) begin
      m_owner = -1; m_last = 1; m_held = 0;
      m_sel = 1'b0; m_out = 4'h0; m_valid = 1'b0;
      return;
    end
    req[0] = REQ0;
    req[1] = REQ1;
    n_out  = (m_owner == 0) ? D0 : (m_owner == 1) ? D1 : 4'h0;
    if (m_owner < 0) begin
      if (REQ0 && REQ1) nxt = 1 - m_last;
      else if (REQ0)    nxt = 0;
      else if (REQ1)    nxt = 1;
      else              nxt = -1;
    end else begin
      other  = 1 - m_owner;
      forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
      forced = (m_held >= MAX_HOLD) && req[other];
`endif
      if (forced)                nxt = other;
      else if (req[m_owner])     nxt = m_owner;
      else if (req[other])       nxt = other;
      else                       nxt = -1;
    end
    if (nxt < 0)               m_held = 0;
    else if (nxt != m_owner)   m_held = 1;
    else                       m_held = m_held + 1;
    if (nxt >= 0) begin
      m_last = nxt;
      m_sel  = (nxt == 1);
    end
    m_valid = (m_owner >= 0);
    m_out   = n_out;
    m_owner = nxt;
  endtask

  // One clock: edge, model update, then compare every output shortly after.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check("gnt0",  {3'b000, GNT0},  {3'b000, (m_owner == 0)});
    check("gnt1",  {3'b000, GNT1},  {3'b000, (m_owner == 1)});
    check("sel",   {3'b000, SEL},   {3'b000, m_sel});
    check("out",   OUT,             m_out);
    check("valid", {3'b000, VALID}, {3'b000, m_valid});
    check("excl",  {3'b000, (GNT0 & GNT1)}, 4'h0);
  endtask

  initial begin
    int gnt0_cycles;
    int gnt1_cycles;
    bit exp_g0;

    m_owner = -1; m_last = 1; m_held = 0;
    m_sel = 1'b0; m_out = 4'h0; m_valid = 1'b0;

    // Reset held two cycles with both requesting; first tie goes to requester 0.
    reset = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'h3; D1 = 4'hA;
    cycle();
    cycle();
    check("rst_out",   OUT,             4'h0);
    check("rst_valid", {3'b000, VALID}, 4'h0);
    reset = 1'b1;
    cycle();
    check("tie_gnt0",  {3'b000, GNT0},  4'h1);
    check("tie_valid", {3'b000, VALID}, 4'h0);
    cycle();
    check("first_out",   OUT,             4'h3);
    check("first_valid", {3'b000, VALID}, 4'h1);
    cycle();

    // REQ0 drops while REQ1 waits: direct hand-over without an IDLE bubble.
    REQ0 = 1'b0;
    cycle();
    check("handover_gnt1",  {3'b000, GNT1},  4'h1);
    check("handover_sel",   {3'b000, SEL},   4'h1);
    check("handover_valid", {3'b000, VALID}, 4'h1);
    check("handover_out0",  OUT,             4'h3);
    cycle();
    check("handover_outA",  OUT,             4'hA);
    check("handover_valid2",{3'b000, VALID}, 4'h1);

    // Reset in the middle of GRANT1 aborts the transaction immediately.
    reset = 1'b0;
    cycle();
    check("abort_gnt1",  {3'b000, GNT1},  4'h0);
    check("abort_valid", {3'b000, VALID}, 4'h0);
    check("abort_out",   OUT,             4'h0);
    check("abort_sel",   {3'b000, SEL},   4'h0);
    reset = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    cycle();

    // Single-cycle request: granted once, then released.
    REQ1 = 1'b1; D1 = 4'h5;
    cycle();
    check("pulse_gnt1", {3'b000, GNT1}, 4'h1);
    REQ1 = 1'b0;
    cycle();
    check("pulse_rel",  {3'b000, GNT1}, 4'h0);
    check("pulse_out",  OUT,            4'h5);
    cycle();

    // Alternating ties: each owner releases after one cycle while the other waits.
    reset = 1'b0;
    cycle();
    reset = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
    cycle();
    check("alt_start", {3'b000, GNT0}, 4'h1);
    for (int i = 1; i <= 4; i++) begin
      if (i % 2 == 1) begin REQ0 = 1'b0; REQ1 = 1'b1; end
      else            begin REQ0 = 1'b1; REQ1 = 1'b0; end
      cycle();
      check("alt_gnt0", {3'b000, GNT0}, {3'b000, (i % 2 == 0)});
      check("alt_gnt1", {3'b000, GNT1}, {3'b000, (i % 2 == 1)});
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    cycle();
    cycle();

    // Both held high for 40 cycles from a fresh reset.
    reset = 1'b0;
    cycle();
    reset = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
    gnt0_cycles = 0;
    gnt1_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
`ifdef ARB_TIMEOUT_EN
      exp_g0 = ((k / MAX_HOLD) % 2) == 0;
`else
      exp_g0 = 1'b1;
`endif
      check("hold_gnt0", {3'b000, GNT0}, {3'b000, exp_g0});
      if (GNT0) gnt0_cycles++;
      if (GNT1) gnt1_cycles++;
    end
`ifndef ARB_TIMEOUT_EN
    check("hold_total0", gnt0_cycles[3:0], 4'(40));
    check("hold_total1", gnt1_cycles[3:0], 4'h0);
`endif
    REQ0 = 1'b0; REQ1 = 1'b0;
    cycle();

    // Random traffic with persistent requests and occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3, 0) == 0) REQ0 = ~REQ0;
      if ($urandom_range(3, 0) == 0) REQ1 = ~REQ1;
      D0    = 4'($urandom_range(15, 0));
      D1    = 4'($urandom_range(15, 0));
      reset = ($urandom_range(39, 0) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
